alu_cmd_issuer: RTL and testbench

ALU_CMD_ISSUER -- requirements
Module: alu_cmd_issuer

---
 rtl/alu_cmd_issuer.sv | 174 +++++++++++++++++
 tb/tb_alu_cmd_issuer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: buffers {opcode, operand} commands in a FIFO and, once started,
// drains them one at a time into an ALU. Each command gets a valid/ready handshake
// and then a wait for the result. The result wait is bounded by a timeout.
module alu_cmd_issuer #(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [11:0] wr_data,
  input  logic        start,
  output logic [3:0]  sel,
  output logic [7:0]  opnd,
  output logic        op_valid,
  input  logic        op_ready,
  input  logic        res_valid,
  input  logic [7:0]  res_data,
  output logic [7:0]  result,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned DW = 12;
  localparam int unsigned TW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t         state, state_nx;

  logic [DW-1:0]  mem [DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count, count_nx;
  logic [DW-1:0]  head;
  logic           push, pop;

  logic [TW-1:0]  tcnt, tcnt_nx;
  logic [3:0]     sel_nx;
  logic [7:0]     opnd_nx;
  logic [7:0]     result_nx;
  logic           err_nx;
  logic           op_valid_nx, done_nx, busy_nx;
  logic           full_nx, empty_nx;

  // A push is dropped while full, even when a pop happens in the same cycle.
  assign push = wr_en & ~full;
  assign head = mem[rd_ptr];

  // FIFO storage. It has no reset because the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO pointers and occupancy. The pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      full  <= full_nx;
      empty <= empty_nx;
    end
  end

  // Next occupancy and the flags derived from it, registered alongside the count.
  always_comb begin
    count_nx = count + CW'(push) - CW'(pop);
    full_nx  = (count_nx == CW'(DEPTH));
    empty_nx = (count_nx == '0);
  end

  // FSM state and all registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      tcnt     <= '0;
      sel      <= '0;
      opnd     <= '0;
      result   <= '0;
      err      <= 1'b0;
      op_valid <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nx;
      tcnt     <= tcnt_nx;
      sel      <= sel_nx;
      opnd     <= opnd_nx;
      result   <= result_nx;
      err      <= err_nx;
      op_valid <= op_valid_nx;
      done     <= done_nx;
      busy     <= busy_nx;
    end
  end

  // Next-state logic. Outputs are derived from the next state so they line up with it.
  always_comb begin
    state_nx  = state;
    pop       = 1'b0;
    tcnt_nx   = tcnt;
    sel_nx    = sel;
    opnd_nx   = opnd;
    result_nx = result;
    err_nx    = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          err_nx   = 1'b0;
          state_nx = S_FETCH;
        end
      end
      S_FETCH: begin
        if (count != '0) begin
          pop      = 1'b1;
          sel_nx   = head[11:8];
          opnd_nx  = head[7:0];
          state_nx = S_ISSUE;
        end else begin
          state_nx = S_DONE;
        end
      end
      S_ISSUE: begin
        if (op_ready) begin
          tcnt_nx  = '0;
          state_nx = S_WAIT;
        end
      end
      S_WAIT: begin
        if (res_valid) begin
          result_nx = res_data;
          state_nx  = S_FETCH;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th cycle without a result. Queued entries stay in the FIFO.
          err_nx   = 1'b1;
          state_nx = S_DONE;
        end else begin
          tcnt_nx = tcnt + TW'(1);
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase

    op_valid_nx = (state_nx == S_ISSUE);
    done_nx     = (state_nx == S_DONE);
    busy_nx     = (state_nx != S_IDLE);
  end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Scoreboard bench for alu_cmd_issuer: directed command streams, a simple ALU responder,
// and a monitor that checks handshakes and done pulses against queued expectations.
module tb_alu_cmd_issuer;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [11:0] wr_data;
  logic        start;
  logic [3:0]  sel;
  logic [7:0]  opnd;
  logic        op_valid;
  logic        op_ready;
  logic        res_valid = 1'b0;
  logic [7:0]  res_data  = 8'h00;
  logic [7:0]  result;
  logic        full, empty, busy, done, err;

  int total = 0;
  int bad   = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic resp_en;

  logic [11:0] exp_cmd[$];
  logic [8:0]  exp_done[$];
  logic [7:0]  rsp_q[$];

  alu_cmd_issuer #(.DEPTH(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .start(start),
    .sel(sel), .opnd(opnd), .op_valid(op_valid), .op_ready(op_ready),
    .res_valid(res_valid), .res_data(res_data), .result(result),
    .full(full), .empty(empty), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ALU responder: one cycle after an accepted handshake, present one result for one cycle.
  always begin
    @(negedge clk);
    if (!rst && resp_en && op_valid && op_ready) begin
      @(posedge clk);
      #1;
      res_valid = 1'b1;
      res_data  = (rsp_q.size() > 0) ? rsp_q.pop_front() : 8'hEE;
      @(posedge clk);
      #1;
      res_valid = 1'b0;
    end
  end

  // Monitor: checks handshakes, the stability of a stalled command, and done pulses.
  always @(negedge clk) begin
    if (!rst) begin
      if (op_valid && !op_ready && exp_cmd.size() > 0) begin
        check("stall_hold", {20'h0, sel, opnd}, {20'h0, exp_cmd[0]});
      end
      if (op_valid && op_ready) begin
        hs_cnt++;
        if (exp_cmd.size() == 0) begin
          check("unexpected_issue", {20'h0, sel, opnd}, 32'hFFFF_FFFF);
        end else begin
          check("issue", {20'h0, sel, opnd}, {20'h0, exp_cmd.pop_front()});
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done.size() == 0) begin
          check("unexpected_done", {23'h0, err, result}, 32'hFFFF_FFFF);
        end else begin
          check("done_err_result", {23'h0, err, result}, {23'h0, exp_done.pop_front()});
        end
      end
    end
  end

  task automatic push(input logic [11:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(posedge clk);
    #1;
    wr_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({"idle_", nm}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_op_valid(input string nm);
    int n = 0;
    while (!op_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({"opv_", nm}, {31'h0, op_valid}, 32'h1);
  endtask

  task automatic check_reset(input string nm);
    check({nm, "_sel"},      {28'h0, sel},      32'h0);
    check({nm, "_opnd"},     {24'h0, opnd},     32'h0);
    check({nm, "_op_valid"}, {31'h0, op_valid}, 32'h0);
    check({nm, "_result"},   {24'h0, result},   32'h0);
    check({nm, "_done"},     {31'h0, done},     32'h0);
    check({nm, "_err"},      {31'h0, err},      32'h0);
    check({nm, "_busy"},     {31'h0, busy},     32'h0);
    check({nm, "_empty"},    {31'h0, empty},    32'h1);
    check({nm, "_full"},     {31'h0, full},     32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs0, dn0;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; start = 1'b0; op_ready = 1'b1; resp_en = 1'b1;
    #1;
    check_reset("rst0");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Two commands, two results, and one done pulse with the final result.
    hs0 = hs_cnt; dn0 = done_cnt;
    push(12'h005); push(12'h103);
    exp_cmd.push_back(12'h005); exp_cmd.push_back(12'h103);
    rsp_q.push_back(8'h08); rsp_q.push_back(8'h02);
    exp_done.push_back({1'b0, 8'h02});
    pulse_start();
    wait_idle("two_cmds");
    check("two_cmds_hs", hs_cnt - hs0, 2);
    check("two_cmds_done", done_cnt - dn0, 1);
    check("two_cmds_result", {24'h0, result}, 32'h02);

    // Fill past capacity: the ninth push is dropped and exactly eight commands issue.
    hs0 = hs_cnt;
    for (int i = 0; i < 9; i++) begin
      push({4'h2, 8'(i)});
      if (i == 6) check("full_after_7", {31'h0, full}, 32'h0);
      if (i == 7) check("full_after_8", {31'h0, full}, 32'h1);
      if (i < 8) begin
        exp_cmd.push_back({4'h2, 8'(i)});
        rsp_q.push_back(8'h30 + 8'(i));
      end
    end
    check("full_after_9", {31'h0, full}, 32'h1);
    check("not_empty_full", {31'h0, empty}, 32'h0);
    exp_done.push_back({1'b0, 8'h37});
    pulse_start();
    wait_idle("fill");
    check("fill_hs", hs_cnt - hs0, 8);
    check("fill_empty", {31'h0, empty}, 32'h1);

    // Start with an empty FIFO: FETCH, then DONE, with no issue.
    hs0 = hs_cnt;
    exp_done.push_back({1'b0, 8'h37});
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("empty_fetch_busy", {31'h0, busy}, 32'h1);
    check("empty_fetch_done", {31'h0, done}, 32'h0);
    @(posedge clk); #1;
    check("empty_done_pulse", {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    check("empty_done_drop", {31'h0, done}, 32'h0);
    check("empty_idle", {31'h0, busy}, 32'h0);
    check("empty_no_issue", hs_cnt - hs0, 0);

    // Back-pressure: hold op_ready low for five cycles, then issue the command once.
    hs0 = hs_cnt;
    op_ready = 1'b0;
    push(12'h3A5);
    exp_cmd.push_back(12'h3A5);
    rsp_q.push_back(8'h5A);
    exp_done.push_back({1'b0, 8'h5A});
    pulse_start();
    wait_op_valid("stall");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall_opv", {31'h0, op_valid}, 32'h1);
    end
    check("stall_no_hs", hs_cnt - hs0, 0);
    op_ready = 1'b1;
    wait_idle("stall");
    check("stall_hs_once", hs_cnt - hs0, 1);

    // Timeout: no result returns, err sets after 15 WAIT cycles, and queued entries survive.
    resp_en = 1'b0;
    push(12'h411); push(12'h522); push(12'h633);
    exp_cmd.push_back(12'h411);
    exp_done.push_back({1'b1, 8'h5A});
    pulse_start();
    wait_op_valid("tmo");
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      @(posedge clk); #1;
    end
    check("tmo_err_before", {31'h0, err}, 32'h0);
    check("tmo_busy_before", {31'h0, busy}, 32'h1);
    @(posedge clk); #1;
    check("tmo_err_set", {31'h0, err}, 32'h1);
    check("tmo_done", {31'h0, done}, 32'h1);
    @(posedge clk); #1;
    check("tmo_idle", {31'h0, busy}, 32'h0);
    check("tmo_err_sticky", {31'h0, err}, 32'h1);
    check("tmo_remaining", {31'h0, empty}, 32'h0);
    resp_en = 1'b1;
    hs0 = hs_cnt;
    exp_cmd.push_back(12'h522); exp_cmd.push_back(12'h633);
    rsp_q.push_back(8'h71); rsp_q.push_back(8'h72);
    exp_done.push_back({1'b0, 8'h72});
    pulse_start();
    check("tmo_err_cleared", {31'h0, err}, 32'h0);
    wait_idle("tmo_drain");
    check("tmo_drain_hs", hs_cnt - hs0, 2);

    // Reset while waiting for a result with three entries still queued.
    resp_en = 1'b0;
    push(12'h701); push(12'h702); push(12'h703); push(12'h704);
    exp_cmd.push_back(12'h701);
    pulse_start();
    wait_op_valid("rst_mid");
    @(posedge clk); #1;
    check("rst_mid_in_wait", {31'h0, busy & ~op_valid}, 32'h1);
    #2;
    rst = 1'b1;
    #1;
    check_reset("rst_mid");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    resp_en = 1'b1;
    hs0 = hs_cnt;
    exp_done.push_back({1'b0, 8'h00});
    pulse_start();
    wait_idle("after_rst");
    check("after_rst_no_issue", hs_cnt - hs0, 0);

    check("exp_cmd_drained", exp_cmd.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
